ft_debug_responder: RTL and testbench
=====================================

Name: ft_debug_responder

Overview:
- Responder (slave) end of the per-core debug port that the fault-tolerance controller drives: halt/resume, req/gnt/rvalid accesses, 15-bit address, 32-bit data.
- Sits between one core's debug pins and that core's pipeline, register-file write/read port and next-PC logic.
- On `debug_halt_i` it stalls the core and reports halted. While halted it services GPR and NPC reads and writes.
- On `debug_resume_i` it restarts the core, redirecting the PC if NPC was written.

Parameters:
- GPR_BASE, 15'h0400, base address of GPR window; GPR index = addr[4:0], window GPR_BASE..GPR_BASE+31.
- NPC_ADDR, 15'h2000, next-PC register address (read/write).
- PPC_ADDR, 15'h2004, PC captured at halt (read-only).
- NUM_GPR, 32, implemented GPRs (16 for RV32E); index >= NUM_GPR is unmapped.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- debug_req_i  in  1  access request.
- debug_gnt_o  out  1  access granted this cycle.
- debug_rvalid_o  out  1  response valid, one cycle after grant.
- debug_addr_i  in  15  access address.
- debug_we_i  in  1  1 = write.
- debug_wdata_i  in  32  write data.
- debug_rdata_o  out  32  read data, valid with rvalid.
- debug_halt_i  in  1  halt request (level).
- debug_resume_i  in  1  resume request (level).
- debug_halted_o  out  1  core halted.
- core_idle_i  in  1  core pipeline drained, no outstanding memory transaction.
- pc_i  in  32  PC of next instruction to execute.
- stall_o  out  1  stop fetch/issue.
- rf_raddr_o  out  5  register-file read address.
- rf_rdata_i  in  32  register-file read data, combinational from rf_raddr_o.
- rf_we_o  out  1  register-file write enable.
- rf_waddr_o  out  5  register-file write address.
- rf_wdata_o  out  32  register-file write data.
- npc_we_o  out  1  one-cycle PC redirect strobe.
- npc_o  out  32  redirect target.

Behaviour:
- **Reset:** `rst_i` high forces every registered output to 0 and the state to RUN. `debug_gnt_o` is gated to 0 during reset. Reset mid-access drops the pending rvalid, rf_we and npc_we; `npc_dirty` is cleared.
- **State machine RUN/HALTING/HALTED/RESUME:**
  - RUN: stall_o=0. `debug_halt_i` → HALTING. `debug_resume_i` is ignored.
  - HALTING: stall_o=1. When `core_idle_i`=1 → HALTED and `ppc`/`npc` ← `pc_i`. `debug_resume_i` is ignored (halt completes first).
  - HALTED: stall_o=1, debug_halted_o=1 (registered, asserted the cycle after entry). `debug_resume_i`=1 → RESUME. Resume wins over a simultaneously held `debug_halt_i`.
  - RESUME (one cycle): stall_o=1, debug_halted_o=0. If `npc_dirty`: npc_we_o=1, npc_o=npc, `npc_dirty` cleared. Then → RUN. If `debug_halt_i` is still high in RUN, the block re-halts.
- **Halt timing:** minimum halt latency is halt request → debug_halted_o in 2 cycles, given `core_idle_i` is already 1.
- **Access handshake:**
  - `debug_gnt_o` = `debug_req_i` & access allowed, combinational, same cycle.
  - GPR/NPC/PPC accesses are allowed only in HALTED; otherwise gnt=0 and the request waits.
  - Unmapped addresses are always granted: read returns 0, write is ignored.
  - `debug_rvalid_o`=1 exactly one cycle after each grant, for reads and writes.
  - `debug_rdata_o` is registered. It holds the read value in the rvalid cycle and is 0 otherwise and for writes.
  - A held req gives one grant per cycle, so throughput is 1 access/cycle with overlapping rvalid.
- **GPR read:** rf_raddr_o = addr[4:0] in the grant cycle; rf_rdata_i is sampled at that edge. Index 0 returns 0.
- **GPR write:** in the cycle after grant (same as rvalid), rf_we_o=1 with rf_waddr_o/rf_wdata_o registered from the grant cycle. Writes to index 0 are suppressed (rf_we_o stays 0).
- **NPC:** write updates `npc` and sets `npc_dirty`; a read returns the current `npc`. PPC read returns `ppc`; PPC write is ignored.
- **Access during transition:** an access granted in the final HALTED cycle (resume asserted) still completes its rvalid/rf_we in the RESUME cycle.
- **Idle outputs:** rf_waddr_o, rf_wdata_o and rf_raddr_o are 0 when not in use.

Test Plan:
1. **Halt entry:** reset, pc_i=0x80, core_idle_i=1, debug_halt_i=1 → stall_o=1 next cycle, debug_halted_o=1 two cycles later, read 0x2004 returns 0x80.
2. **GPR write/read:** halted, write 0x0405 data 0xDEADBEEF → gnt same cycle; next cycle rvalid=1, rf_we_o=1, rf_waddr_o=5. Then read 0x0405 with rf_rdata_i=0xDEADBEEF → rdata 0xDEADBEEF with rvalid.
3. **x0 handling:** write 0x0400 data 0x1 → rvalid=1, rf_we_o stays 0. Read 0x0400 → rdata 0.
4. **NPC redirect:** write 0x2000 data 0x0000_0100, then resume → single npc_we_o pulse with npc_o=0x100, debug_halted_o=0, stall_o=0 the following cycle. A second halt/resume without an NPC write gives no npc_we_o.
5. **Gated access:** in RUN, req to 0x0403 → gnt=0 until HALTED, then granted. Req to unmapped 0x1000 in RUN → gnt=1, rvalid next cycle, rdata 0.
6. **Resets:** back-to-back reads of 0x0401, 0x0402, 0x0403 give 3 consecutive grants and 3 consecutive rvalids. Then `rst_i` pulsed mid-sequence → rvalid, halted and stall all 0 immediately, state RUN.

Source files
------------

// File: rtl/ft_debug_responder.sv
// ft_debug_responder
//   Responder end of the per-core debug port driven by the fault-tolerance
//   controller. It halts/resumes the core and, while the core is halted,
//   services GPR, NPC (next PC) and PPC (PC captured at halt) accesses.
//
// Ports
//   clk_i, rst_i                     clock, async active-high reset
//   debug_req_i / debug_gnt_o        access request / same-cycle grant
//   debug_addr_i, debug_we_i,        access address, write flag, write data
//   debug_wdata_i
//   debug_rvalid_o, debug_rdata_o    response one cycle after grant
//   debug_halt_i, debug_resume_i     halt / resume request levels
//   debug_halted_o                   core is halted
//   core_idle_i, pc_i                pipeline drained flag, next-instruction PC
//   stall_o                          stop fetch/issue
//   rf_raddr_o, rf_rdata_i           register-file read port (combinational)
//   rf_we_o, rf_waddr_o, rf_wdata_o  register-file write port
//   npc_we_o, npc_o                  one-cycle PC redirect on resume
module ft_debug_responder #(
  parameter logic [14:0] GPR_BASE = 15'h0400,
  parameter logic [14:0] NPC_ADDR = 15'h2000,
  parameter logic [14:0] PPC_ADDR = 15'h2004,
  parameter int unsigned NUM_GPR  = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        debug_req_i,
  output logic        debug_gnt_o,
  output logic        debug_rvalid_o,
  input  logic [14:0] debug_addr_i,
  input  logic        debug_we_i,
  input  logic [31:0] debug_wdata_i,
  output logic [31:0] debug_rdata_o,
  input  logic        debug_halt_i,
  input  logic        debug_resume_i,
  output logic        debug_halted_o,
  input  logic        core_idle_i,
  input  logic [31:0] pc_i,
  output logic        stall_o,
  output logic [4:0]  rf_raddr_o,
  input  logic [31:0] rf_rdata_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        npc_we_o,
  output logic [31:0] npc_o
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HALTING,
    ST_HALTED,
    ST_RESUME
  } state_t;

  state_t      state;
  logic [31:0] npc;
  logic [31:0] ppc;
  logic        npc_dirty;

  // Address decode
  logic [14:0] gpr_off;
  logic [4:0]  gpr_idx;
  logic        hit_gpr;
  logic        hit_npc;
  logic        hit_ppc;
  logic        hit_mapped;

  assign gpr_off    = debug_addr_i - GPR_BASE;
  assign gpr_idx    = debug_addr_i[4:0];
  assign hit_gpr    = (debug_addr_i >= GPR_BASE) && (gpr_off < 15'd32) &&
                      (32'(gpr_idx) < NUM_GPR);
  assign hit_npc    = (debug_addr_i == NPC_ADDR);
  assign hit_ppc    = (debug_addr_i == PPC_ADDR);
  assign hit_mapped = hit_gpr || hit_npc || hit_ppc;

  // Access qualification and read mux
  logic        gpr_wr;
  logic        npc_wr;
  logic [31:0] rd_val;

  always_comb begin
    // Unmapped addresses never wait: they complete as a null access.
    debug_gnt_o = debug_req_i && !rst_i && (!hit_mapped || state == ST_HALTED);
    rf_raddr_o  = (debug_gnt_o && hit_gpr && !debug_we_i) ? gpr_idx : '0;
    gpr_wr      = debug_gnt_o && debug_we_i && hit_gpr && (gpr_idx != 5'd0);
    npc_wr      = debug_gnt_o && debug_we_i && hit_npc;
    rd_val      = '0;
    if (hit_gpr) begin
      rd_val = (gpr_idx == 5'd0) ? '0 : rf_rdata_i;
    end else if (hit_npc) begin
      rd_val = npc;
    end else if (hit_ppc) begin
      rd_val = ppc;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= ST_RUN;
      npc            <= '0;
      ppc            <= '0;
      npc_dirty      <= 1'b0;
      debug_rvalid_o <= 1'b0;
      debug_rdata_o  <= '0;
      debug_halted_o <= 1'b0;
      stall_o        <= 1'b0;
      rf_we_o        <= 1'b0;
      rf_waddr_o     <= '0;
      rf_wdata_o     <= '0;
      npc_we_o       <= 1'b0;
      npc_o          <= '0;
    end else begin
      // Response stage: every grant produces exactly one rvalid next cycle.
      debug_rvalid_o <= debug_gnt_o;
      debug_rdata_o  <= (debug_gnt_o && !debug_we_i) ? rd_val : '0;
      rf_we_o        <= gpr_wr;
      rf_waddr_o     <= gpr_wr ? gpr_idx : '0;
      rf_wdata_o     <= gpr_wr ? debug_wdata_i : '0;
      npc_we_o       <= 1'b0;
      npc_o          <= '0;

      if (npc_wr) begin
        npc       <= debug_wdata_i;
        npc_dirty <= 1'b1;
      end

      case (state)
        ST_RUN: begin
          if (debug_halt_i) begin
            state   <= ST_HALTING;
            stall_o <= 1'b1;
          end
        end
        ST_HALTING: begin
          if (core_idle_i) begin
            state          <= ST_HALTED;
            debug_halted_o <= 1'b1;
            ppc            <= pc_i;
            npc            <= pc_i;
          end
        end
        ST_HALTED: begin
          if (debug_resume_i) begin
            state          <= ST_RESUME;
            debug_halted_o <= 1'b0;
            // The redirect strobe is launched here so it is visible in the
            // RESUME cycle; an NPC write granted in this same cycle counts.
            npc_we_o       <= npc_dirty || npc_wr;
            if (npc_dirty || npc_wr) begin
              npc_o <= npc_wr ? debug_wdata_i : npc;
            end
            npc_dirty      <= 1'b0;
          end
        end
        ST_RESUME: begin
          state   <= ST_RUN;
          stall_o <= 1'b0;
        end
        default: begin
          state          <= ST_RUN;
          stall_o        <= 1'b0;
          debug_halted_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ft_debug_responder.sv
module tb_ft_debug_responder;

  localparam logic [14:0] A_NPC = 15'h2000;
  localparam logic [14:0] A_PPC = 15'h2004;

  logic        clk;
  logic        rst;
  logic        req;
  logic        gnt;
  logic        rvalid;
  logic [14:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        halt;
  logic        resume;
  logic        halted;
  logic        idle;
  logic [31:0] pc;
  logic        stall;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        npc_we;
  logic [31:0] npc_out;

  ft_debug_responder #(
    .GPR_BASE(15'h0400),
    .NPC_ADDR(15'h2000),
    .PPC_ADDR(15'h2004),
    .NUM_GPR (32)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .debug_req_i   (req),
    .debug_gnt_o   (gnt),
    .debug_rvalid_o(rvalid),
    .debug_addr_i  (addr),
    .debug_we_i    (we),
    .debug_wdata_i (wdata),
    .debug_rdata_o (rdata),
    .debug_halt_i  (halt),
    .debug_resume_i(resume),
    .debug_halted_o(halted),
    .core_idle_i   (idle),
    .pc_i          (pc),
    .stall_o       (stall),
    .rf_raddr_o    (rf_raddr),
    .rf_rdata_i    (rf_rdata),
    .rf_we_o       (rf_we),
    .rf_waddr_o    (rf_waddr),
    .rf_wdata_o    (rf_wdata),
    .npc_we_o      (npc_we),
    .npc_o         (npc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Core register file seen by the responder; x0 holds garbage on purpose.
  logic [31:0] regs [32];
  always_comb rf_rdata = regs[rf_raddr];

  // Reference model: core debug mode plus the expected registered outputs.
  localparam int M_RUN = 0, M_HALTING = 1, M_HALTED = 2, M_RESUME = 3;
  int          m_mode;
  logic [31:0] m_npc, m_ppc;
  bit          m_dirty;
  logic        e_rvalid, e_rfwe, e_npcwe, e_halted, e_stall;
  logic [31:0] e_rdata, e_wdata, e_npc;
  logic [4:0]  e_waddr;

  function automatic bit is_gpr(input logic [14:0] a);
    return (a >= 15'h0400) && (a <= 15'h041F);
  endfunction

  function automatic bit is_mapped(input logic [14:0] a);
    return is_gpr(a) || a == A_NPC || a == A_PPC;
  endfunction

  function automatic bit exp_gnt();
    return req && !rst && (!is_mapped(addr) || m_mode == M_HALTED);
  endfunction

  task automatic model_reset();
    m_mode = M_RUN; m_dirty = 0; m_npc = '0; m_ppc = '0;
    e_rvalid = 0; e_rfwe = 0; e_npcwe = 0; e_halted = 0; e_stall = 0;
    e_rdata = '0; e_wdata = '0; e_npc = '0; e_waddr = '0;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      bit g;
      int idx;
      g = exp_gnt();
      e_rvalid = g; e_rdata = '0; e_rfwe = 0; e_waddr = '0; e_wdata = '0;
      e_npcwe = 0; e_npc = '0;
      if (g) begin
        if (is_gpr(addr)) begin
          idx = int'(addr) - 32'h400;
          if (we) begin
            if (idx != 0) begin
              e_rfwe = 1; e_waddr = 5'(idx); e_wdata = wdata; regs[idx] = wdata;
            end
          end else begin
            e_rdata = (idx == 0) ? 32'h0 : regs[idx];
          end
        end else if (addr == A_NPC) begin
          if (we) begin m_npc = wdata; m_dirty = 1; end
          else e_rdata = m_npc;
        end else if (addr == A_PPC && !we) begin
          e_rdata = m_ppc;
        end
      end
      case (m_mode)
        M_RUN:     if (halt) m_mode = M_HALTING;
        M_HALTING: if (idle) begin m_mode = M_HALTED; m_ppc = pc; m_npc = pc; end
        M_HALTED:  if (resume) begin
                     m_mode = M_RESUME;
                     if (m_dirty) begin e_npcwe = 1; e_npc = m_npc; end
                     m_dirty = 0;
                   end
        default:   m_mode = M_RUN;
      endcase
      e_stall  = (m_mode != M_RUN);
      e_halted = (m_mode == M_HALTED);
    end
  end

  // Compare process, on the falling edge.
  always @(negedge clk) begin
    if (rst) model_reset();
    check("gnt", gnt, exp_gnt());
    check("raddr", rf_raddr,
          (exp_gnt() && is_gpr(addr) && !we) ? 32'(addr[4:0]) : 32'h0);
    check("rvalid", rvalid, e_rvalid);
    check("rdata", rdata, e_rdata);
    check("rf_we", rf_we, e_rfwe);
    check("rf_waddr", rf_waddr, e_waddr);
    check("rf_wdata", rf_wdata, e_wdata);
    check("npc_we", npc_we, e_npcwe);
    if (e_npcwe) check("npc", npc_out, e_npc);
    check("halted", halted, e_halted);
    check("stall", stall, e_stall);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One access with literal expectations; returns at +3 of the rvalid cycle.
  task automatic acc(input logic [14:0] a, input logic w, input logic [31:0] d,
                     input logic [31:0] exp_rd, input logic exp_rfwe);
    step();
    addr = a; we = w; wdata = d; req = 1;
    #2;
    check("acc_gnt", gnt, 1);
    step();
    req = 0; we = 0;
    #2;
    check("acc_rvalid", rvalid, 1);
    check("acc_rdata", rdata, exp_rd);
    check("acc_rf_we", rf_we, exp_rfwe);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'hBAD0_0001;
    rst = 1; req = 0; addr = '0; we = 0; wdata = '0;
    halt = 0; resume = 0; idle = 0; pc = '0;
    repeat (3) step();
    #2;
    check("rst_halted", halted, 0);
    check("rst_stall", stall, 0);
    check("rst_rvalid", rvalid, 0);
    step();
    rst = 0;

    // Halt entry
    step();
    pc = 32'h80; idle = 1; halt = 1;
    step(); #2;
    check("halt_stall", stall, 1);
    check("halt_not_yet", halted, 0);
    step();
    check("halt_halted", halted, 1);
    halt = 0;
    acc(A_PPC, 0, 0, 32'h80, 0);

    // GPR write/read
    acc(15'h0405, 1, 32'hDEADBEEF, 32'h0, 1);
    check("gpr_waddr", rf_waddr, 5);
    check("gpr_wdata", rf_wdata, 32'hDEADBEEF);
    acc(15'h0405, 0, 0, 32'hDEADBEEF, 0);

    // x0
    acc(15'h0400, 1, 32'h1, 32'h0, 0);
    acc(15'h0400, 0, 0, 32'h0, 0);

    // NPC redirect
    acc(A_NPC, 1, 32'h100, 32'h0, 0);
    acc(A_NPC, 0, 0, 32'h100, 0);
    step();
    resume = 1;
    step();
    resume = 0;
    #2;
    check("res_npc_we", npc_we, 1);
    check("res_npc", npc_out, 32'h100);
    check("res_halted", halted, 0);
    step(); #2;
    check("res_stall", stall, 0);
    check("res_npc_we_off", npc_we, 0);
    step();
    halt = 1;
    step();
    step();
    check("rehalt", halted, 1);
    halt = 0; resume = 1;
    step();
    resume = 0;
    #2;
    check("res2_no_npc_we", npc_we, 0);
    step(); #2;
    check("res2_stall", stall, 0);

    // Gated access in RUN
    step();
    addr = 15'h0403; we = 0; req = 1;
    #2; check("gated_0", gnt, 0);
    step(); #2; check("gated_1", gnt, 0);
    halt = 1;
    n = 0;
    do begin step(); #2; n++; end while (!gnt && n < 8);
    check("gated_grant", gnt, 1);
    halt = 0;
    step();
    req = 0;
    #2;
    check("gated_rvalid", rvalid, 1);
    check("gated_rdata", rdata, regs[3]);
    resume = 1;
    step();
    resume = 0;
    step(); #2;
    check("run_stall", stall, 0);
    acc(15'h1000, 0, 0, 32'h0, 0);

    // Back-to-back reads then reset mid-sequence
    halt = 1;
    step();
    step();
    halt = 0;
    req = 1; addr = 15'h0401;
    #2; check("b2b_gnt1", gnt, 1);
    step();
    addr = 15'h0402;
    #2; check("b2b_gnt2", gnt, 1); check("b2b_rv1", rvalid, 1); check("b2b_rd1", rdata, regs[1]);
    step();
    addr = 15'h0403;
    #2; check("b2b_gnt3", gnt, 1); check("b2b_rv2", rvalid, 1); check("b2b_rd2", rdata, regs[2]);
    step();
    check("b2b_rv3", rvalid, 1);
    addr = 15'h1000;
    rst = 1;
    #1;
    check("mid_rst_rvalid", rvalid, 0);
    check("mid_rst_halted", halted, 0);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_gnt", gnt, 0);
    step();
    rst = 0; req = 0;

    // Randomised traffic
    for (int c = 0; c < 4000; c++) begin
      step();
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 15) == 0) halt = ~halt;
      if ($urandom_range(0, 15) == 0) resume = ~resume;
      idle  = ($urandom_range(0, 3) != 0);
      pc    = $urandom;
      req   = $urandom_range(0, 1);
      we    = $urandom_range(0, 1);
      wdata = $urandom;
      case ($urandom_range(0, 5))
        0, 1: addr = 15'h0400 + 15'($urandom_range(0, 31));
        2:    addr = A_NPC;
        3:    addr = A_PPC;
        4:    addr = 15'h1000;
        default: addr = 15'($urandom);
      endcase
    end
    step();
    rst = 1; req = 0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
